// File: rtl/execute_stage.sv
// RISC-V execute stage: forwarding operand muxes, ALU, branch/jump resolution,
// and the EX/MEM pipeline register with stall/flush control.
module execute_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [WIDTH-1:0]      id_rd1,
    input  logic [WIDTH-1:0]      id_rd2,
    input  logic [WIDTH-1:0]      id_imm,
    input  logic [WIDTH-1:0]      id_pc,
    input  logic [WIDTH-1:0]      id_pc_plus4,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_alu_src,
    input  logic [2:0]            id_alu_cntrl,
    input  logic                  id_reg_write,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic [1:0]            id_result_src,
    input  logic [1:0]            fwd_a,
    input  logic [1:0]            fwd_b,
    input  logic [WIDTH-1:0]      wb_result,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  pc_src,
    output logic [WIDTH-1:0]      pc_target,
    output logic                  mem_valid,
    output logic [WIDTH-1:0]      mem_alu_result,
    output logic [WIDTH-1:0]      mem_write_data,
    output logic [WIDTH-1:0]      mem_pc_plus4,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_write,
    output logic [1:0]            mem_result_src
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic                  mem_valid_d,      mem_valid_q;
    logic [WIDTH-1:0]      mem_alu_result_d, mem_alu_result_q;
    logic [WIDTH-1:0]      mem_write_data_d, mem_write_data_q;
    logic [WIDTH-1:0]      mem_pc_plus4_d,   mem_pc_plus4_q;
    logic [REG_ADDR_W-1:0] mem_rd_d,         mem_rd_q;
    logic                  mem_reg_write_d,  mem_reg_write_q;
    logic                  mem_mem_write_d,  mem_mem_write_q;
    logic [1:0]            mem_result_src_d, mem_result_src_q;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] fwd_b_val;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;
    logic             zero;

    // Operand selection; the MEM-stage source is this stage's own registered result
    always_comb begin
        src_a     = id_rd1;
        fwd_b_val = id_rd2;
        case (fwd_a)
            FWD_WB:  src_a = wb_result;
            FWD_MEM: src_a = mem_alu_result_q;
            default: src_a = id_rd1;
        endcase
        case (fwd_b)
            FWD_WB:  fwd_b_val = wb_result;
            FWD_MEM: fwd_b_val = mem_alu_result_q;
            default: fwd_b_val = id_rd2;
        endcase
        src_b = id_alu_src ? id_imm : fwd_b_val;
    end

    always_comb begin
        alu_result = '0;
        case (id_alu_cntrl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
        zero = (alu_result == '0);
    end

    assign pc_src    = id_valid & ((id_branch & zero) | id_jump);
    assign pc_target = id_pc + id_imm;

    // EX/MEM next state: flush beats stall; flushed data fields simply hold
    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_alu_result_d = mem_alu_result_q;
        mem_write_data_d = mem_write_data_q;
        mem_pc_plus4_d   = mem_pc_plus4_q;
        mem_rd_d         = mem_rd_q;
        mem_reg_write_d  = mem_reg_write_q;
        mem_mem_write_d  = mem_mem_write_q;
        mem_result_src_d = mem_result_src_q;
        if (flush) begin
            mem_valid_d     = 1'b0;
            mem_reg_write_d = 1'b0;
            mem_mem_write_d = 1'b0;
        end else if (!stall) begin
            mem_valid_d      = id_valid;
            mem_alu_result_d = alu_result;
            mem_write_data_d = fwd_b_val;
            mem_pc_plus4_d   = id_pc_plus4;
            mem_rd_d         = id_rd;
            mem_reg_write_d  = id_reg_write & id_valid & (id_rd != '0);
            mem_mem_write_d  = id_mem_write & id_valid;
            mem_result_src_d = id_result_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_write_data_q <= '0;
            mem_pc_plus4_q   <= '0;
            mem_rd_q         <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_result_src_q <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_write_data_q <= mem_write_data_d;
            mem_pc_plus4_q   <= mem_pc_plus4_d;
            mem_rd_q         <= mem_rd_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_result_src_q <= mem_result_src_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_pc_plus4   = mem_pc_plus4_q;
    assign mem_rd         = mem_rd_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_result_src = mem_result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a per-cycle reference model plus
// hand-computed literal expectations from the test plan.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc, id_pc_plus4;
    logic [4:0]  id_rd;
    logic        id_alu_src;
    logic [2:0]  id_alu_cntrl;
    logic        id_reg_write, id_mem_write, id_branch, id_jump;
    logic [1:0]  id_result_src, fwd_a, fwd_b;
    logic [31:0] wb_result;
    logic        stall, flush;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_valid;
    logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus4;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_write;
    logic [1:0]  mem_result_src;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    execute_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_rd(id_rd), .id_alu_src(id_alu_src),
        .id_alu_cntrl(id_alu_cntrl), .id_reg_write(id_reg_write),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump),
        .id_result_src(id_result_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .wb_result(wb_result), .stall(stall), .flush(flush),
        .pc_src(pc_src), .pc_target(pc_target), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .mem_result_src(mem_result_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural meaning of each ALU code
    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] reg_val,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (f == 2'b01) return wb;
        if (f == 2'b10) return mem;
        return reg_val;
    endfunction

    logic        e_valid = 1'b0, e_rw = 1'b0, e_mw = 1'b0, e_data_dc = 1'b0;
    logic [31:0] e_alu = '0, e_wd = '0, e_pc4 = '0;
    logic [4:0]  e_rd = '0;
    logic [1:0]  e_rs = '0;

    function automatic logic [31:0] m_b();
        return pick(fwd_b, id_rd2, wb_result, e_alu);
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] a;
        a = pick(fwd_a, id_rd1, wb_result, e_alu);
        return alu(id_alu_cntrl, a, id_alu_src ? id_imm : m_b());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e_valid <= 0; e_rw <= 0; e_mw <= 0; e_data_dc <= 0;
            e_alu <= '0; e_wd <= '0; e_pc4 <= '0; e_rd <= '0; e_rs <= '0;
        end else if (flush) begin
            e_valid <= 0; e_rw <= 0; e_mw <= 0; e_data_dc <= 1;
        end else if (!stall) begin
            e_valid   <= id_valid;
            e_rw      <= id_reg_write && id_valid && id_rd != 0;
            e_mw      <= id_mem_write && id_valid;
            e_alu     <= m_result();
            e_wd      <= m_b();
            e_pc4     <= id_pc_plus4;
            e_rd      <= id_rd;
            e_rs      <= id_result_src;
            e_data_dc <= 0;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_pc_src", 32'(pc_src),
                32'(id_valid && ((id_branch && m_result() == 0) || id_jump)));
            chk("m_pc_target", pc_target, id_pc + id_imm);
            chk("m_valid", 32'(mem_valid), 32'(e_valid));
            chk("m_reg_write", 32'(mem_reg_write), 32'(e_rw));
            chk("m_mem_write", 32'(mem_mem_write), 32'(e_mw));
            if (!e_data_dc) begin
                chk("m_alu_result", mem_alu_result, e_alu);
                chk("m_write_data", mem_write_data, e_wd);
                chk("m_pc_plus4", mem_pc_plus4, e_pc4);
                chk("m_rd", 32'(mem_rd), 32'(e_rd));
                chk("m_result_src", 32'(mem_result_src), 32'(e_rs));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_pc = 0; id_pc_plus4 = 0;
        id_rd = 0; id_alu_src = 0; id_alu_cntrl = 0; id_reg_write = 0; id_mem_write = 0;
        id_branch = 0; id_jump = 0; id_result_src = 0; fwd_a = 0; fwd_b = 0;
        wb_result = 0; stall = 0; flush = 0;
    endtask

    task automatic instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        nop();
        id_valid = 1; id_alu_cntrl = op; id_rd1 = a; id_rd2 = b; id_rd = rd;
        id_reg_write = rw; id_pc = 32'h200; id_pc_plus4 = 32'h204; id_result_src = 2'b01;
    endtask

    initial begin
        nop();
        rst = 1;
        tick(); tick();
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_alu", mem_alu_result, 0);
        chk("rst_pc4", mem_pc_plus4, 0);
        rst = 0;
        check_en = 1;

        // ADD register path
        instr(3'b000, 5, 7, 3, 1);
        tick();
        chk("add_res", mem_alu_result, 12);
        chk("add_rd", 32'(mem_rd), 3);
        chk("add_rw", 32'(mem_reg_write), 1);
        chk("add_valid", 32'(mem_valid), 1);

        // SUB + BEQ taken
        instr(3'b001, 32'h10, 32'h10, 0, 0);
        id_branch = 1; id_pc = 32'h100; id_imm = 32'h20;
        #1;
        chk("beq_pc_src", 32'(pc_src), 1);
        chk("beq_target", pc_target, 32'h120);
        tick();
        chk("sub_res", mem_alu_result, 0);

        // BEQ not taken
        instr(3'b001, 32'h10, 32'h11, 0, 0);
        id_branch = 1;
        #1;
        chk("bne_pc_src", 32'(pc_src), 0);
        tick();
        chk("sub_neg", mem_alu_result, 32'hFFFFFFFF);

        // Forward from MEM plus immediate wraps to 0
        instr(3'b000, 32'h1234, 0, 4, 1);
        fwd_a = 2'b10; id_alu_src = 1; id_imm = 1;
        tick();
        chk("fwd_mem_wrap", mem_alu_result, 0);

        // Forward B from WB into both ALU and store data
        instr(3'b000, 3, 32'h77, 5, 0);
        fwd_b = 2'b01; wb_result = 9; id_mem_write = 1;
        tick();
        chk("fwd_wb_wd", mem_write_data, 9);
        chk("fwd_wb_res", mem_alu_result, 12);
        chk("fwd_wb_mw", 32'(mem_mem_write), 1);

        // Store data ignores the immediate
        instr(3'b000, 1, 32'h55, 6, 0);
        id_alu_src = 1; id_imm = 4; id_mem_write = 1; fwd_a = 2'b11;
        tick();
        chk("wd_not_imm", mem_write_data, 32'h55);
        chk("imm_res", mem_alu_result, 5);

        // SLT signed and other ops
        instr(3'b101, 32'h80000000, 1, 7, 1);
        tick();
        chk("slt_neg", mem_alu_result, 1);
        instr(3'b101, 1, 32'h80000000, 7, 1);
        tick();
        chk("slt_swap", mem_alu_result, 0);
        instr(3'b010, 32'hF0F0, 32'hFF00, 8, 1);
        tick();
        chk("and_res", mem_alu_result, 32'hF000);
        instr(3'b011, 32'hF0F0, 32'h0F00, 8, 1);
        tick();
        chk("or_res", mem_alu_result, 32'hFFF0);
        instr(3'b110, 32'hF0F0, 32'h0F00, 8, 1);
        tick();
        chk("op110_res", mem_alu_result, 0);

        // Jump redirects; a bubble with jump does not
        instr(3'b000, 1, 1, 1, 1);
        id_jump = 1; id_pc = 32'h400; id_imm = 32'hFFFFFFF0;
        #1;
        chk("jal_pc_src", 32'(pc_src), 1);
        chk("jal_target", pc_target, 32'h3F0);
        tick();
        nop();
        id_jump = 1; id_reg_write = 1; id_rd = 9;
        #1;
        chk("bubble_jump_pc_src", 32'(pc_src), 0);
        tick();
        chk("bubble_valid", 32'(mem_valid), 0);
        chk("bubble_rw", 32'(mem_reg_write), 0);

        // Stall holds for 3 cycles even while inputs change
        instr(3'b000, 5, 7, 3, 1);
        tick();
        stall = 1; id_rd1 = 100; id_rd = 12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_res", mem_alu_result, 12);
            chk("stall_rd", 32'(mem_rd), 3);
        end
        flush = 1; id_mem_write = 1;
        tick();
        chk("flush_valid", 32'(mem_valid), 0);
        chk("flush_rw", 32'(mem_reg_write), 0);
        chk("flush_mw", 32'(mem_mem_write), 0);

        // Reset during stall, then x0 write suppression
        instr(3'b000, 20, 22, 10, 1);
        tick();
        stall = 1;
        tick();
        rst = 1;
        tick();
        chk("rst_mid_valid", 32'(mem_valid), 0);
        chk("rst_mid_res", mem_alu_result, 0);
        chk("rst_mid_rd", 32'(mem_rd), 0);
        chk("rst_mid_rw", 32'(mem_reg_write), 0);
        rst = 0;
        instr(3'b000, 2, 2, 0, 1);
        tick();
        chk("x0_rw", 32'(mem_reg_write), 0);
        chk("x0_valid", 32'(mem_valid), 1);
        chk("x0_res", mem_alu_result, 4);

        nop();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipelined RISC-V execute stage. It sits between the ID/EX boundary and the EX/MEM pipeline register, and consumes the 3-bit ALU control word produced by the ALU decoder. It also:
- selects operands, applying forwarding and the immediate,
- performs the ALU operation,
- resolves branch and jump redirects,
- registers the results into EX/MEM, with stall and flush control from the hazard unit.

## Interface
- WIDTH, 32, datapath width
- REG_ADDR_W, 5, register-address width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID/EX slot holds a real instruction
- id_rd1, id_rd2  input  WIDTH  register-file read data
- id_imm  input  WIDTH  sign-extended immediate
- id_pc  input  WIDTH  instruction PC
- id_pc_plus4  input  WIDTH  PC+4
- id_rd  input  REG_ADDR_W  destination register
- id_alu_src  input  1  0: operand B from register path; 1: operand B = id_imm
- id_alu_cntrl  input  3  ALU control from the ALU decoder
- id_reg_write, id_mem_write, id_branch, id_jump  input  1 each  control bits
- id_result_src  input  2  00 ALU, 01 memory, 10 PC+4 (passed through)
- fwd_a, fwd_b  input  2  00 register data, 01 wb_result, 10 mem_alu_result
- wb_result  input  WIDTH  writeback-stage value
- stall  input  1  hold the EX/MEM register
- flush  input  1  load a bubble into EX/MEM
- pc_src  output  1  redirect fetch (combinational)
- pc_target  output  WIDTH  id_pc + id_imm (combinational)
- mem_valid  output  1  registered
- mem_alu_result, mem_write_data, mem_pc_plus4  output  WIDTH  registered
- mem_rd  output  REG_ADDR_W  registered
- mem_reg_write, mem_mem_write  output  1  registered
- mem_result_src  output  2  registered

## Operation
Operand selection:
- srcA comes from fwd_a: 00 selects id_rd1, 01 selects wb_result, 10 selects mem_alu_result, 11 selects id_rd1.
- The forwarded B value is chosen the same way from id_rd2 under fwd_b.
- srcB is id_imm when id_alu_src=1; otherwise it is the forwarded B value.
- mem_write_data always captures the forwarded B value, never the immediate.

ALU operations (alu_cntrl):
- 000: ADD
- 001: SUB
- 010: AND
- 011: OR
- 101: SLT, signed; result is 1 or 0, zero-extended
- 100, 110, 111: result 0

Arithmetic rules:
- All arithmetic is modulo 2^WIDTH; overflow is ignored.
- zero = (ALU result == 0).

Branch resolution:
- pc_src = id_valid & ((id_branch & zero) | id_jump).
- pc_src and pc_target are combinational and are not gated by stall or flush.

EX/MEM register update, in priority order:
1. rst: every registered output is cleared to 0.
2. flush: mem_valid, mem_reg_write and mem_mem_write are cleared to 0; the data fields may take any value.
3. stall: all registered outputs hold.
4. Otherwise: load all fields from the current inputs, with:
   - mem_valid = id_valid
   - mem_reg_write = id_reg_write & id_valid
   - mem_mem_write = id_mem_write & id_valid

Register x0:
- When id_rd = 0, mem_reg_write is forced to 0.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the mem_* outputs after edge N.
- Reset value of every registered output is 0. pc_src is 0 while id_valid=0.
- Reset asserted mid-stream clears the outputs at the next edge, regardless of stall or flush.
- When stall and flush are asserted together, flush wins.
- Stall is held for multiple cycles: outputs stay stable for the entire duration. The upstream stage must hold its id_* inputs during a stall.
- Forwarding inputs are used in the same cycle they are presented; there is no internal forwarding.
- id_valid=0 with id_jump=1: no redirect, and a bubble is registered.

## Test plan
- ADD, register path: id_rd1=5, id_rd2=7, alu_cntrl=000, alu_src=0, id_rd=3, reg_write=1 -> next cycle mem_alu_result=12, mem_rd=3, mem_reg_write=1, mem_valid=1.
- SUB and BEQ taken: id_rd1=id_rd2=0x10, alu_cntrl=001, branch=1, id_pc=0x100, id_imm=0x20 -> same cycle pc_src=1, pc_target=0x120; next cycle mem_alu_result=0.
- Forwarding and immediate: fwd_a=10 with mem_alu_result=0xFFFFFFFF, alu_src=1, id_imm=1, alu_cntrl=000 -> result 0 (wrap-around). Then fwd_b=01 with wb_result=9, alu_src=0 -> mem_write_data=9.
- SLT signed: srcA=0x80000000, srcB=1, alu_cntrl=101 -> result 1. Swapped operands -> result 0.
- Stall and flush: load an ADD, then stall for 3 cycles -> outputs unchanged. Assert stall and flush together -> mem_valid=0, mem_reg_write=0, mem_mem_write=0.
- Reset and x0: assert rst mid-stall -> all registered outputs 0 next cycle. After reset, an instruction with id_rd=0 and reg_write=1 -> mem_reg_write=0.
